or_gate: RTL and testbench

OR_GATE -- requirements
Module: or_gate

---
 rtl/or_gate.sv | 73 +++++++
 tb/tb_or_gate.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/or_gate.sv
// Bitwise OR of two operands with a registered copy, a sticky "seen any
// bit set" flag and a saturating counter of 0->1 transitions of that
// reduction.
module or_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             clr,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_Q,
    output logic             ANY,
    output logic             STICKY,
    output logic [CNT_W-1:0] RISE_CNT
);

    logic [WIDTH-1:0] w_out;
    logic             w_any;
    logic             w_rise;
    logic             w_sat;

    logic [WIDTH-1:0] r_out_q;
    logic             r_any_d;
    logic             r_sticky;
    logic [CNT_W-1:0] r_rise_cnt;

    // Combinational OR path and rise detection against last sampled ANY
    always_comb begin
        w_out  = X | Y;
        w_any  = |w_out;
        w_rise = w_any & ~r_any_d;
        w_sat  = &r_rise_cnt;
    end

    // Data path registers; clr deliberately does not touch these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= WIDTH'(0);
            r_any_d <= 1'b0;
        end else begin
            r_out_q <= w_out;
            r_any_d <= w_any;
        end
    end

    // Sticky flag and saturating rise counter; clr wins over a same-edge rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky   <= 1'b0;
            r_rise_cnt <= CNT_W'(0);
        end else if (clr) begin
            r_sticky   <= 1'b0;
            r_rise_cnt <= CNT_W'(0);
        end else begin
            if (w_any) begin
                r_sticky <= 1'b1;
            end
            if (w_rise && !w_sat) begin
                r_rise_cnt <= r_rise_cnt + CNT_W'(1);
            end
        end
    end

    assign OUT      = w_out;
    assign ANY      = w_any;
    assign OUT_Q    = r_out_q;
    assign STICKY   = r_sticky;
    assign RISE_CNT = r_rise_cnt;

endmodule

// File: tb/tb_or_gate.sv
// Directed bench for or_gate: a 1-bit/4-bit-counter instance for the
// truth table, counting, saturation, clear and reset, plus an 8-bit
// instance for multi-bit OR and reduction behaviour.
module tb_or_gate;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [0:0] x1, y1;
    logic [0:0] out1, out_q1;
    logic       any1, sticky1;
    logic [3:0] cnt1;
    logic [7:0] x8, y8;
    logic [7:0] out8, out_q8;
    logic       any8, sticky8;
    logic [15:0] cnt8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    or_gate #(.WIDTH(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .X(x1), .Y(y1), .clr(clr),
        .OUT(out1), .OUT_Q(out_q1), .ANY(any1), .STICKY(sticky1), .RISE_CNT(cnt1)
    );

    or_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .X(x8), .Y(y8), .clr(clr),
        .OUT(out8), .OUT_Q(out_q8), .ANY(any8), .STICKY(sticky8), .RISE_CNT(cnt8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one edge with ANY driven to v on the 1-bit instance
    task automatic drive_any(input logic v);
        x1 = v;
        y1 = 1'b0;
        tick();
    endtask

    logic [1:0] xy;
    logic [3:0] exp_cnt;

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        x1 = 1'b0; y1 = 1'b0;
        x8 = 8'h00; y8 = 8'h00;
        #1;
        chk("rst_out_q", 64'(out_q1), 64'd0);
        chk("rst_sticky", 64'(sticky1), 64'd0);
        chk("rst_cnt", 64'(cnt1), 64'd0);

        // truth table during reset, 5 time units per step
        for (int i = 0; i < 4; i++) begin
            xy = 2'(i);
            x1 = xy[1];
            y1 = xy[0];
            #1;
            chk($sformatf("tt_out_%0d", i), 64'(out1), (i == 0) ? 64'd0 : 64'd1);
            chk($sformatf("tt_any_%0d", i), 64'(any1), (i == 0) ? 64'd0 : 64'd1);
            #4;
        end
        chk("rst_hold_out_q", 64'(out_q1), 64'd0);

        // multi-bit OR and reduction
        x8 = 8'hA0; y8 = 8'h05; #1;
        chk("w8_out_a5", 64'(out8), 64'hA5);
        chk("w8_any_a5", 64'(any8), 64'd1);
        x8 = 8'h00; y8 = 8'h00; #1;
        chk("w8_any_0", 64'(any8), 64'd0);
        x8 = 8'h00; y8 = 8'h80; #1;
        chk("w8_out_80", 64'(out8), 64'h80);
        chk("w8_any_80", 64'(any8), 64'd1);
        x8 = 8'h3C; y8 = 8'hC3; #1;
        chk("w8_out_ff", 64'(out8), 64'hFF);

        // leave reset with ANY=0
        x1 = 1'b0; y1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("w8_out_q_ff", 64'(out_q8), 64'hFF);
        chk("w8_sticky", 64'(sticky8), 64'd1);
        chk("w8_cnt", 64'(cnt8), 64'd1);
        chk("idle_cnt", 64'(cnt1), 64'd0);

        // registered path
        x1 = 1'b1; y1 = 1'b0;
        tick();
        chk("reg_out_q_1", 64'(out_q1), 64'd1);
        chk("reg_cnt_1", 64'(cnt1), 64'd1);
        x1 = 1'b0; y1 = 1'b0;
        chk("reg_out_q_hold", 64'(out_q1), 64'd1);
        tick();
        chk("reg_out_q_0", 64'(out_q1), 64'd0);
        chk("sticky_hold", 64'(sticky1), 64'd1);

        // clear with ANY=0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", 64'(cnt1), 64'd0);
        chk("clr_sticky", 64'(sticky1), 64'd0);

        // rise counting: ANY = 0,1,1,0,1
        drive_any(1'b0);
        chk("rc_sticky_0", 64'(sticky1), 64'd0);
        drive_any(1'b1);
        chk("rc_cnt_a", 64'(cnt1), 64'd1);
        drive_any(1'b1);
        chk("rc_cnt_b", 64'(cnt1), 64'd1);
        drive_any(1'b0);
        drive_any(1'b1);
        chk("rc_cnt", 64'(cnt1), 64'd2);
        chk("rc_sticky", 64'(sticky1), 64'd1);

        // saturation with 4-bit counter
        clr = 1'b1;
        drive_any(1'b0);
        clr = 1'b0;
        exp_cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            drive_any(1'b1);
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            chk($sformatf("sat_%0d", i), 64'(cnt1), 64'(exp_cnt));
            drive_any(1'b0);
        end
        chk("sat_final", 64'(cnt1), 64'd15);

        // clear beats a simultaneous rise
        clr = 1'b1;
        drive_any(1'b1);
        clr = 1'b0;
        chk("cp_cnt", 64'(cnt1), 64'd0);
        chk("cp_sticky", 64'(sticky1), 64'd0);
        chk("cp_out_q", 64'(out_q1), 64'd1);
        drive_any(1'b0);
        chk("cp_cnt_idle", 64'(cnt1), 64'd0);
        drive_any(1'b1);
        chk("cp_cnt_next", 64'(cnt1), 64'd1);
        chk("cp_sticky_next", 64'(sticky1), 64'd1);

        // reach count 5, then async reset between edges
        for (int i = 0; i < 4; i++) begin
            drive_any(1'b0);
            drive_any(1'b1);
        end
        chk("ar_pre_cnt", 64'(cnt1), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", 64'(cnt1), 64'd0);
        chk("ar_sticky", 64'(sticky1), 64'd0);
        chk("ar_out_q", 64'(out_q1), 64'd0);
        chk("ar_out", 64'(out1), 64'd1);
        chk("ar_w8_cnt", 64'(cnt8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rise", 64'(cnt1), 64'd1);
        chk("post_rst_sticky", 64'(sticky1), 64'd1);
        chk("post_rst_out_q", 64'(out_q1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
